// File: rtl/switch_capture_if.sv
// ---------------------------------------------------------------------------
// switch_capture_if
//   Groups the board-side inputs and the display-side outputs of
//   switch_capture.
//   sw        8  raw slide switches (asynchronous)
//   btnLoad   1  raw LOAD push-button, active-high
//   btnClr    1  raw CLEAR push-button, active-high
//   dataOut   8  captured word for the display's dataIn
//   dataValid 1  one-cycle pulse when dataOut takes a new value
//   loadCount 4  accepted LOAD presses, mod 16
//   master: drives the raw inputs and observes the outputs (board / bench)
//   slave : the capture stage itself
// ---------------------------------------------------------------------------
interface switch_capture_if;
   logic [7:0] sw;
   logic       btnLoad;
   logic       btnClr;
   logic [7:0] dataOut;
   logic       dataValid;
   logic [3:0] loadCount;

   modport master (output sw, btnLoad, btnClr,
                   input  dataOut, dataValid, loadCount);
   modport slave  (input  sw, btnLoad, btnClr,
                   output dataOut, dataValid, loadCount);
endinterface

// File: rtl/switch_capture.sv
// ---------------------------------------------------------------------------
// switch_capture
//   Input stage of the rotating display. The raw switches and the LOAD and
//   CLEAR buttons are synchronised. Each button is debounced and
//   edge-detected. A LOAD press latches the switches into dataOut. A CLEAR
//   press zeroes dataOut. If both presses land on the same edge, CLEAR wins.
//   dataOut holds between presses.
//
//   Ports:
//     clk  in  system clock
//     rst  in  synchronous, active-high reset
//     bus  switch_capture_if.slave (sw, btnLoad, btnClr in;
//          dataOut, dataValid, loadCount out)
//
//   Parameters:
//     DBWIDTH  debounce counter width. A debounced value follows its input
//              after 2**DBWIDTH consecutive differing edges.
//
//   Build option:
//     SWITCH_DEBOUNCE_EN  when defined, every switch bit is debounced like
//                         a button and LOAD captures the debounced value.
//                         Otherwise LOAD captures the synchronised switches.
//
//   Latency from a clean LOAD rise to the new dataOut is 2 + 2**DBWIDTH + 2
//   edges: 2 sync, 2**DBWIDTH debounce, 1 registered press, 1 capture.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// switch_capture_db
//   Single-bit debouncer.
//     sync_i    synchronised input
//     stable_o  debounced value
//   The counter only runs while the input differs from the stable value.
//   Any sample that agrees with the stable value restarts the count.
// ---------------------------------------------------------------------------
module switch_capture_db #(
   parameter int DBWIDTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_i,
   output logic stable_o
);
   logic [DBWIDTH-1:0] cnt_q, cnt_d;
   logic               stab_q, stab_d;

   always_comb begin
      cnt_d  = cnt_q;
      stab_d = stab_q;
      if (sync_i == stab_q) begin
         cnt_d = '0;
      end else if (&cnt_q) begin
         // This is the 2**DBWIDTH-th consecutive differing edge.
         stab_d = sync_i;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + DBWIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         stab_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         stab_q <= stab_d;
      end
   end

   assign stable_o = stab_q;
endmodule

module switch_capture #(
   parameter int DBWIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   switch_capture_if.slave  bus
);
   localparam int NRAW = 10;   // 8 switches + LOAD + CLEAR

   // Two-flop synchroniser on every raw input.
   // Bit layout: [9] CLEAR, [8] LOAD, [7:0] switches.
   logic [NRAW-1:0] meta_q, sync_q;
   logic [NRAW-1:0] raw;

   assign raw = {bus.btnClr, bus.btnLoad, bus.sw};

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
      end
   end

   // Button debounce: index 0 is LOAD, index 1 is CLEAR.
   logic [1:0] btn_stab;

   for (genvar b = 0; b < 2; b++) begin : g_btn_db
      switch_capture_db #(.DBWIDTH(DBWIDTH)) u_db (
         .clk      (clk),
         .rst      (rst),
         .sync_i   (sync_q[8+b]),
         .stable_o (btn_stab[b])
      );
   end

   // Switch value that LOAD captures.
   logic [7:0] sw_use;

`ifdef SWITCH_DEBOUNCE_EN
   for (genvar i = 0; i < 8; i++) begin : g_sw_db
      switch_capture_db #(.DBWIDTH(DBWIDTH)) u_db (
         .clk      (clk),
         .rst      (rst),
         .sync_i   (sync_q[i]),
         .stable_o (sw_use[i])
      );
   end
`else
   assign sw_use = sync_q[7:0];
`endif

   // Rising-edge detect on the debounced buttons. The press is registered,
   // so capture happens one edge after the press is seen. Holding a button
   // yields one press. Releasing it yields none.
   logic [1:0] prev_q, press_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= '0;
         press_q <= '0;
      end else begin
         prev_q  <= btn_stab;
         press_q <= btn_stab & ~prev_q;
      end
   end

   // Capture stage.
   logic [7:0] data_q, data_d;
   logic       vld_q, vld_d;
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      vld_d  = 1'b0;
      if (press_q[1]) begin
         // CLEAR takes priority over a simultaneous LOAD.
         // loadCount does not change on a CLEAR.
         data_d = '0;
         vld_d  = 1'b1;
      end else if (press_q[0]) begin
         data_d = sw_use;
         cnt_d  = cnt_q + 4'd1;   // wraps 15 -> 0
         vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.dataOut   = data_q;
   assign bus.dataValid = vld_q;
   assign bus.loadCount = cnt_q;
endmodule

// File: tb/tb_switch_capture.sv
module tb_switch_capture;
   localparam int DBW = 4;
   localparam int WIN = 1 << DBW;

   logic clk;
   logic rst;
   switch_capture_if bus();

   switch_capture #(.DBWIDTH(DBW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model. Each signal's synchronised value is the raw value
   // from two edges earlier. A debounced value flips once the last WIN
   // synchronised samples all disagree with it. A capture happens two
   // edges after the debounced button rises.
   // ------------------------------------------------------------------
   logic [9:0] r1, r2;          // raw values seen one and two edges ago
   logic [9:0] hist[$];         // recent synchronised samples, newest last
   logic [9:0] stab;
   logic [1:0] sA, sB, sC;      // debounced {clr,load} after edges k-1, k-2, k-3
   logic [7:0] m_do;
   logic       m_dv;
   logic [3:0] m_lc;

   task automatic model_edge(input logic [7:0] s, input logic l, input logic c, input logic r);
      logic [9:0] samp, nst;
      logic [7:0] swu;
      logic       pl, pc, flip;
      if (r) begin
         r1 = '0; r2 = '0; stab = '0; hist.delete();
         sA = '0; sB = '0; sC = '0;
         m_do = '0; m_dv = 1'b0; m_lc = '0;
         return;
      end
      samp = r2;
`ifdef SWITCH_DEBOUNCE_EN
      swu = stab[7:0];
`else
      swu = samp[7:0];
`endif
      pl = sB[0] & ~sC[0];
      pc = sB[1] & ~sC[1];
      if (pc) begin
         m_do = '0;
         m_dv = 1'b1;
      end else if (pl) begin
         m_do = swu;
         m_lc = m_lc + 4'd1;
         m_dv = 1'b1;
      end else begin
         m_dv = 1'b0;
      end
      hist.push_back(samp);
      if (hist.size() > WIN) void'(hist.pop_front());
      nst = stab;
      if (hist.size() == WIN) begin
         for (int b = 0; b < 10; b++) begin
            flip = 1'b1;
            foreach (hist[j]) if (hist[j][b] == stab[b]) flip = 1'b0;
            if (flip) nst[b] = ~stab[b];
         end
      end
      stab = nst;
      sC = sB; sB = sA; sA = stab[9:8];
      r2 = r1;
      r1 = {c, l, s};
   endtask

   // Drive one cycle, advance the model on the edge, then compare #1 later.
   task automatic cyc(input logic [7:0] s, input logic l, input logic c, input logic r);
      bus.sw = s; bus.btnLoad = l; bus.btnClr = c; rst = r;
      @(posedge clk);
      model_edge(s, l, c, r);
      #1;
      chk("dataOut",   bus.dataOut,   m_do);
      chk("dataValid", bus.dataValid, m_dv);
      chk("loadCount", bus.loadCount, m_lc);
   endtask

   initial begin
      logic [7:0] s;
      logic       l, c;
      bus.sw = '0; bus.btnLoad = 1'b0; bus.btnClr = 1'b0; rst = 1'b1;

      // 1: reset with switches set
      for (int i = 0; i < 3; i++) begin
         cyc(8'hA5, 1'b0, 1'b0, 1'b1);
         chk("rst_dout", bus.dataOut, 8'h00);
         chk("rst_dv",   bus.dataValid, 1'b0);
         chk("rst_lc",   bus.loadCount, 4'h0);
      end

      // 2: clean LOAD, held 40 cycles
      for (int i = 1; i <= 40; i++) begin
         cyc(8'h3C, 1'b1, 1'b0, 1'b0);
         chk("t2_dv", bus.dataValid, (i == 20) ? 1'b1 : 1'b0);
         if (i == 20) chk("t2_dout", bus.dataOut, 8'h3C);
      end
      chk("t2_lc", bus.loadCount, 4'd1);
      for (int i = 0; i < 20; i++) cyc(8'h3C, 1'b0, 1'b0, 1'b0);

      // 3: LOAD bouncing every 5 cycles never gets through
      for (int i = 0; i < 60; i++) begin
         cyc(8'h77, ((i / 5) % 2) == 0, 1'b0, 1'b0);
         chk("t3_dv", bus.dataValid, 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         cyc(8'h77, 1'b0, 1'b0, 1'b0);
         chk("t3_dv", bus.dataValid, 1'b0);
      end
      chk("t3_dout", bus.dataOut, 8'h3C);

      // 4: LOAD and CLEAR rise together, so CLEAR wins
      for (int i = 1; i <= 30; i++) begin
         cyc(8'h99, 1'b1, 1'b1, 1'b0);
         chk("t4_dv", bus.dataValid, (i == 20) ? 1'b1 : 1'b0);
      end
      chk("t4_dout", bus.dataOut, 8'h00);
      chk("t4_lc",   bus.loadCount, 4'd1);
      for (int i = 0; i < 25; i++) cyc(8'h99, 1'b0, 1'b0, 1'b0);

      // 5: 17 presses after reset, so loadCount wraps to 1
      for (int i = 0; i < 2; i++) cyc(8'h00, 1'b0, 1'b0, 1'b1);
      for (int p = 0; p < 17; p++) begin
         for (int i = 0; i < 22; i++) cyc(8'(p), 1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 22; i++) cyc(8'(p), 1'b0, 1'b0, 1'b0);
      end
      chk("t5_lc",   bus.loadCount, 4'd1);
      chk("t5_dout", bus.dataOut, 8'h10);

      // 6: reset during a LOAD debounce, button still held afterwards
      for (int i = 0; i < 10; i++) cyc(8'h5A, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)  cyc(8'h5A, 1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 24; i++) begin
         cyc(8'h5A, 1'b1, 1'b0, 1'b0);
         chk("t6_dv", bus.dataValid, (i == WIN + 4) ? 1'b1 : 1'b0);
      end
      chk("t6_lc",   bus.loadCount, 4'd1);
      chk("t6_dout", bus.dataOut, 8'h5A);
      for (int i = 0; i < 20; i++) cyc(8'h5A, 1'b0, 1'b0, 1'b0);

      // Random: slow-toggling buttons with bounce, wandering switches, rare resets
      s = 8'h00; l = 1'b0; c = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(24) == 0) l = ~l;
         if ($urandom_range(29) == 0) c = ~c;
         if ($urandom_range(19) == 0) s = 8'($urandom);
         else if ($urandom_range(9) == 0) s[$urandom_range(7)] ^= 1'b1;
         cyc(s, l, c, $urandom_range(799) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
